// File: rtl/pe_gen_pkg.sv
// Shared definitions for the Generations-family cell PE: command codes,
// cell-state constants, rule-bus layout and the default Conway masks.
package pe_gen_pkg;

    // Broadcast command bus encoding; codes 6 and 7 are treated as NOP.
    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_PROCESS   = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_LOAD_RULE = 3'd4,
        CMD_CLEAR     = 3'd5
    } pe_cmd_e;

    // What the age counter does on the coming clock edge.
    typedef enum logic [1:0] {
        AGE_HOLD  = 2'd0,
        AGE_CLEAR = 2'd1,
        AGE_INC   = 2'd2
    } pe_age_op_e;

    // Fixed cell-state codes; codes 2..N_STATES-1 are dying stages.
    localparam int PE_STATE_DEAD = 0;
    localparam int PE_STATE_LIVE = 1;

    // Rule bus layout: {survive[8:0], birth[8:0]}, each mask indexed by count.
    localparam int RULE_MASK_W      = 9;
    localparam int RULE_BIRTH_LSB   = 0;
    localparam int RULE_SURVIVE_LSB = 9;
    localparam int RULE_W           = 2 * RULE_MASK_W;

    // Conway's Life, B3/S23.
    localparam logic [RULE_MASK_W-1:0] PE_RST_BIRTH   = 9'b000001000;
    localparam logic [RULE_MASK_W-1:0] PE_RST_SURVIVE = 9'b000001100;

endpackage

// File: rtl/pe_gen_next.sv
// Combinational next-state and age-action logic for one Generations cell.
// Kept free of registers so an array-level reference model can reuse it.
module pe_gen_next
    import pe_gen_pkg::*;
#(
    parameter int N_STATES   = 2,
    parameter int STATE_BITS = $clog2(N_STATES)
) (
    input  logic [STATE_BITS-1:0]  state,
    input  logic [3:0]             count,
    input  logic [RULE_MASK_W-1:0] birth,
    input  logic [RULE_MASK_W-1:0] survive,
    input  pe_cmd_e                cmd,
    input  logic                   sel,
    input  logic [STATE_BITS-1:0]  state_in,
    output logic [STATE_BITS-1:0]  nstate,
    output pe_age_op_e             age_op
);

    localparam logic [STATE_BITS-1:0] ST_DEAD = STATE_BITS'(PE_STATE_DEAD);
    localparam logic [STATE_BITS-1:0] ST_LIVE = STATE_BITS'(PE_STATE_LIVE);
    // A LIVE cell that fails survival enters the first dying stage, or dies
    // outright in a plain two-state automaton.
    localparam logic [STATE_BITS-1:0] ST_AFTER_LIVE =
        (N_STATES > 2) ? STATE_BITS'(2) : ST_DEAD;
    localparam logic [STATE_BITS-1:0] ST_LAST = STATE_BITS'(N_STATES - 1);

    logic was_live;
    logic is_live;

    // Rule evaluation: birth/survive for DEAD/LIVE, unconditional decay otherwise.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        nstate = state;
        unique case (cmd)
            CMD_PROCESS: begin
                if (state == ST_DEAD) begin
                    if (birth[count]) nstate = ST_LIVE;
                end else if (state == ST_LIVE) begin
                    if (!survive[count]) nstate = ST_AFTER_LIVE;
                end else begin
                    nstate = (state == ST_LAST) ? ST_DEAD : state + STATE_BITS'(1);
                end
            end
            CMD_WRITE: begin
                if (sel) begin
                    nstate = (int'(state_in) >= N_STATES) ? ST_DEAD : state_in;
                end
            end
            default: ;
        endcase
    end

    assign was_live = (state == ST_LIVE);
    assign is_live  = (nstate == ST_LIVE);

    // Age action: cleared on writes and LIVE boundary crossings, counts LIVE-held generations.
    always_comb begin
        age_op = AGE_HOLD;
        if (cmd == CMD_WRITE && sel) begin
            age_op = AGE_CLEAR;
        end else if (was_live != is_live) begin
            age_op = AGE_CLEAR;
        end else if (cmd == CMD_PROCESS && was_live) begin
            age_op = AGE_INC;
        end
    end

endmodule

// File: rtl/pe_gen.sv
// Generations-family processing element: one cell of the tiled array with a
// run-time rule, multi-stage decay, saturating live age, registered reads and
// a sticky change flag for convergence detection.
module pe_gen
    import pe_gen_pkg::*;
#(
    parameter int                     N_STATES    = 2,
    parameter int                     STATE_BITS  = $clog2(N_STATES),
    parameter int                     AGE_BITS    = 8,
    parameter logic [RULE_MASK_W-1:0] RST_BIRTH   = PE_RST_BIRTH,
    parameter logic [RULE_MASK_W-1:0] RST_SURVIVE = PE_RST_SURVIVE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rsel,
    input  logic                           csel,
    input  logic [2:0]                     cmd,
    input  logic [STATE_BITS-1:0]          state_in,
    input  logic [RULE_W-1:0]              rule_in,
    input  logic                           w_i,
    input  logic                           e_i,
    input  logic                           n_i,
    input  logic                           s_i,
    input  logic                           nw_i,
    input  logic                           ne_i,
    input  logic                           sw_i,
    input  logic                           se_i,
    output logic                           status_out,
    output logic [AGE_BITS+STATE_BITS-1:0] state_out,
    output logic                           rd_valid,
    output logic                           active,
    output logic                           changed
);

    localparam int RD_W = AGE_BITS + STATE_BITS;

    pe_cmd_e                cmd_w;
    logic                   sel;
    logic [3:0]             count;
    logic [STATE_BITS-1:0]  nstate;
    pe_age_op_e             age_op;
    logic                   moving;

    logic [STATE_BITS-1:0]  state_q,   state_d;
    logic [AGE_BITS-1:0]    age_q,     age_d;
    logic [RULE_MASK_W-1:0] birth_q,   birth_d;
    logic [RULE_MASK_W-1:0] survive_q, survive_d;
    logic [RD_W-1:0]        rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   changed_q, changed_d;

    // Codes 6/7 are not enum members and fall through to the NOP defaults.
    assign cmd_w = pe_cmd_e'(cmd);
    assign sel   = rsel & csel;
    assign count = 4'(w_i) + 4'(e_i) + 4'(n_i) + 4'(s_i)
                 + 4'(nw_i) + 4'(ne_i) + 4'(sw_i) + 4'(se_i);

    pe_gen_next #(
        .N_STATES   (N_STATES),
        .STATE_BITS (STATE_BITS)
    ) u_next (
        .state    (state_q),
        .count    (count),
        .birth    (birth_q),
        .survive  (survive_q),
        .cmd      (cmd_w),
        .sel      (sel),
        .state_in (state_in),
        .nstate   (nstate),
        .age_op   (age_op)
    );

    // Held low in reset so the array never sees a phantom change while the cell is forced DEAD.
    assign moving = rst && (nstate != state_q);

    // Next values for every register in the cell.
    always_comb begin
        state_d    = nstate;
        age_d      = age_q;
        birth_d    = birth_q;
        survive_d  = survive_q;
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        changed_d  = changed_q | moving;

        unique case (age_op)
            AGE_CLEAR: age_d = '0;
            AGE_INC:   age_d = (age_q == '1) ? age_q : age_q + AGE_BITS'(1);
            default:   ;
        endcase

        if (cmd_w == CMD_LOAD_RULE) begin
            birth_d   = rule_in[RULE_BIRTH_LSB   +: RULE_MASK_W];
            survive_d = rule_in[RULE_SURVIVE_LSB +: RULE_MASK_W];
        end

        if (cmd_w == CMD_READ && sel) begin
            rd_data_d  = {age_q, state_q};
            rd_valid_d = 1'b1;
        end

        // CLEAR never alters the state, so it cannot race a change in the same cycle.
        if (cmd_w == CMD_CLEAR) changed_d = 1'b0;
    end

    // Cell registers; reset returns the cell to DEAD with the default rule.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= STATE_BITS'(PE_STATE_DEAD);
            age_q      <= '0;
            birth_q    <= RST_BIRTH;
            survive_q  <= RST_SURVIVE;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            changed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            age_q      <= age_d;
            birth_q    <= birth_d;
            survive_q  <= survive_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            changed_q  <= changed_d;
        end
    end

    assign status_out = (state_q == STATE_BITS'(PE_STATE_LIVE));
    assign state_out  = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign active     = moving;
    assign changed    = changed_q;

endmodule
